// File: rtl/alu_div_seq.sv
// ---------------------------------------------------------------------------
// alu_div_seq -- sequential restoring divider that borrows the 32-bit ALU.
//
// Each RUN cycle presents one trial subtract (alu_src1_o - alu_src2_o) to the
// ALU with ALU_control fixed at ALU_SUB_CODE. The ALU returns the difference
// and its no-borrow flag in the same cycle. One division is in flight at a
// time. Requests and results use valid/ready handshakes.
//
// Handshake rules (both sides): a transfer happens on a rising edge where
// valid and ready are both high. The producer holds valid and its payload
// steady until that edge. req_ready_o is high only in IDLE. res_valid_o stays
// high with a stable payload until res_ready_i is seen.
//
// Optional feature: define ALU_DIV_SIGNED_EN to add a signed_i input and a
// FIX state that restores the signs of the quotient and remainder.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   req_valid_i / req_ready_o     request handshake
//   dividend_i, divisor_i         operands, sampled on accept
//   signed_i                      (ALU_DIV_SIGNED_EN only) signed operation
//   alu_src1_o, alu_src2_o        ALU operands: shifted remainder, divisor
//   alu_ctrl_o                    ALU_control, constant ALU_SUB_CODE
//   alu_result_i, alu_cout_i      ALU difference and no-borrow flag
//   res_valid_o / res_ready_i     result handshake
//   quotient_o, remainder_o       result payload
//   div_zero_o                    divisor was zero (qualified by res_valid_o)
// ---------------------------------------------------------------------------
module alu_div_seq #(
    parameter int         WIDTH        = 32,
    parameter logic [3:0] ALU_SUB_CODE = 4'b0110
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
`ifdef ALU_DIV_SIGNED_EN
    input  logic             signed_i,
`endif
    output logic [WIDTH-1:0] alu_src1_o,
    output logic [WIDTH-1:0] alu_src2_o,
    output logic [3:0]       alu_ctrl_o,
    input  logic [WIDTH-1:0] alu_result_i,
    input  logic             alu_cout_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_zero_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
`ifdef ALU_DIV_SIGNED_EN
        , S_FIX = 2'd3
`endif
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] q_q;        // quotient shift register; dividend bits shift out the top
    logic [WIDTH-1:0] r_q;        // partial remainder
    logic [WIDTH-1:0] src1_q;     // always holds the shifted remainder S of the current step
    logic [WIDTH-1:0] src2_q;     // latched divisor
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [CW-1:0]    cnt_q;
    logic             req_ready_q;
    logic             res_valid_q;
    logic             div_zero_q;

    // One restoring step. hi is the bit shifted out of R. When it is set,
    // {hi,S} >= D is guaranteed, and the ALU's modulo difference is still the
    // correct new remainder.
    logic [WIDTH-1:0] s_step;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] src1_d;
    logic             hi;
    logic             ok;

    assign s_step = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
    assign hi     = r_q[WIDTH-1];
    assign ok     = hi | alu_cout_i;
    assign r_d    = ok ? alu_result_i : s_step;
    assign q_d    = {q_q[WIDTH-2:0], ok};
    // Preload the next step's S. This keeps alu_src1_o registered while the
    // ALU still sees S in the cycle that uses it.
    assign src1_d = {r_d[WIDTH-2:0], q_q[WIDTH-2]};

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;

`ifdef ALU_DIV_SIGNED_EN
    logic sign_a;
    logic sign_b;
    logic neg_q_q;
    logic neg_r_q;

    assign sign_a  = signed_i & dividend_i[WIDTH-1];
    assign sign_b  = signed_i & divisor_i[WIDTH-1];
    assign dvd_mag = sign_a ? -dividend_i : dividend_i;
    assign dvs_mag = sign_b ? -divisor_i  : divisor_i;
`else
    assign dvd_mag = dividend_i;
    assign dvs_mag = divisor_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            q_q         <= '0;
            r_q         <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            div_zero_q  <= 1'b0;
`ifdef ALU_DIV_SIGNED_EN
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        cnt_q       <= CW'(WIDTH - 1);
`ifdef ALU_DIV_SIGNED_EN
                        neg_q_q     <= sign_a ^ sign_b;
                        neg_r_q     <= sign_a;
`endif
                        if (divisor_i == '0) begin
                            // Skip the ALU entirely. The remainder is the raw dividend.
                            quo_q       <= '1;
                            rem_q       <= dividend_i;
                            div_zero_q  <= 1'b1;
                            res_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            q_q     <= dvd_mag;
                            r_q     <= '0;
                            src1_q  <= {{(WIDTH-1){1'b0}}, dvd_mag[WIDTH-1]};
                            src2_q  <= dvs_mag;
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_q <= r_d;
                    q_q <= q_d;
                    if (cnt_q == '0) begin
`ifdef ALU_DIV_SIGNED_EN
                        state_q     <= S_FIX;
`else
                        quo_q       <= q_d;
                        rem_q       <= r_d;
                        res_valid_q <= 1'b1;
                        state_q     <= S_DONE;
`endif
                    end else begin
                        cnt_q  <= cnt_q - 1'b1;
                        src1_q <= src1_d;
                    end
                end
`ifdef ALU_DIV_SIGNED_EN
                S_FIX: begin
                    quo_q       <= neg_q_q ? -q_q : q_q;
                    rem_q       <= neg_r_q ? -r_q : r_q;
                    res_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
`endif
                S_DONE: begin
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        div_zero_q  <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign res_valid_o = res_valid_q;
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;
    assign div_zero_o  = div_zero_q;
    assign alu_src1_o  = src1_q;
    assign alu_src2_o  = src2_q;
    assign alu_ctrl_o  = ALU_SUB_CODE;

endmodule

// File: tb/tb_alu_div_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_div_seq -- self-checking bench for alu_div_seq.
// Provides a behavioural 32-bit ALU (subtract, cout = no borrow). Runs a
// table of directed vectors, randomized vectors against an arithmetic
// reference model, and hand-written back-pressure and mid-run reset
// sequences.
// ---------------------------------------------------------------------------
module tb_alu_div_seq;

    localparam int W = 32;
`ifdef ALU_DIV_SIGNED_EN
    localparam int RUN_LAT = W + 2;
`else
    localparam int RUN_LAT = W + 1;
`endif

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
`ifdef ALU_DIV_SIGNED_EN
    logic         signed_in;
`endif
    logic [W-1:0] alu_src1;
    logic [W-1:0] alu_src2;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] alu_result;
    logic         alu_cout;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    always #5 clk = ~clk;

    // Behavioural ALU: combinational subtract with a no-borrow carry out.
    always_comb begin
        alu_result = alu_src1 - alu_src2;
        alu_cout   = (alu_src1 >= alu_src2);
    end

    alu_div_seq dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .dividend_i   (dividend),
        .divisor_i    (divisor),
`ifdef ALU_DIV_SIGNED_EN
        .signed_i     (signed_in),
`endif
        .alu_src1_o   (alu_src1),
        .alu_src2_o   (alu_src2),
        .alu_ctrl_o   (alu_ctrl),
        .alu_result_i (alu_result),
        .alu_cout_i   (alu_cout),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .quotient_o   (quotient),
        .remainder_o  (remainder),
        .div_zero_o   (div_zero)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [2*W:0] exp_q[$];   // {div_zero, quotient, remainder}

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on magnitudes, with signs restored afterwards.
    function automatic logic [2*W:0] model_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic sgn);
        logic [W-1:0] ma, mb, mq, mr, rq, rr;
        logic         na, nb;
        if (b == '0) return {1'b1, {W{1'b1}}, a};
        na = sgn && a[W-1];
        nb = sgn && b[W-1];
        ma = na ? (~a + 32'd1) : a;
        mb = nb ? (~b + 32'd1) : b;
        mq = ma / mb;
        mr = ma % mb;
        rq = (na ^ nb) ? (~mq + 32'd1) : mq;
        rr = na ? (~mr + 32'd1) : mr;
        return {1'b0, rq, rr};
    endfunction

    // ---------------- driver ----------------
    // Called at #1 after a rising edge, with the DUT in IDLE.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                           input int exp_lat, input int hold, input string tag);
        logic [2*W:0] exp;
        int           lat;
        check({tag, " req_ready before"}, {31'd0, req_ready}, 32'd1);
        dividend  = a;
        divisor   = b;
`ifdef ALU_DIV_SIGNED_EN
        signed_in = sgn;
`endif
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        exp = exp_q.pop_front();
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " quotient"}, quotient, exp[2*W-1:W]);
        check({tag, " remainder"}, remainder, exp[W-1:0]);
        check({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, exp[2*W]});
        check({tag, " alu_ctrl"}, {28'd0, alu_ctrl}, 32'h6);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check({tag, " res_valid after ack"}, {31'd0, res_valid}, 32'd0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sgn;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

`ifdef ALU_DIV_SIGNED_EN
    localparam int NTBL = 14;
`else
    localparam int NTBL = 10;
`endif
    vec_t tbl[NTBL];

    initial begin
        tbl[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
        tbl[1] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0};
        tbl[2] = '{32'hFFFF_FFFF,  32'h8000_0001,  1'b0, 32'd1,          32'h7FFF_FFFE,  1'b0};
        tbl[3] = '{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1'b1};
        tbl[4] = '{32'd0,          32'd5,          1'b0, 32'd0,          32'd0,          1'b0};
        tbl[5] = '{32'd7,          32'd7,          1'b0, 32'd1,          32'd0,          1'b0};
        tbl[6] = '{32'd6,          32'd7,          1'b0, 32'd0,          32'd6,          1'b0};
        tbl[7] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0};
        tbl[8] = '{32'hDEAD_BEEF,  32'd16,         1'b0, 32'h0DEA_DBEE,  32'hF,          1'b0};
        tbl[9] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0,          1'b0};
`ifdef ALU_DIV_SIGNED_EN
        tbl[10] = '{32'hFFFF_FFF9, 32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
        tbl[11] = '{32'h8000_0000, 32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0};
        tbl[12] = '{32'd7,         32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0};
        tbl[13] = '{32'hFFFF_FFF9, 32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1};
`endif
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] a, b, hq, hr;
        logic         hdz;
        int           lat;

        rst       = 1'b1;
        req_valid = 1'b0;
        res_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
`ifdef ALU_DIV_SIGNED_EN
        signed_in = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset req_ready", {31'd0, req_ready}, 32'd1);
        check("reset res_valid", {31'd0, res_valid}, 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        check("reset div_zero", {31'd0, div_zero}, 32'd0);
        check("reset src1", alu_src1, 32'd0);
        check("reset src2", alu_src2, 32'd0);
        check("reset alu_ctrl", {28'd0, alu_ctrl}, 32'h6);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table: expectations come from the table itself.
        for (int i = 0; i < NTBL; i++) begin
            exp_q.push_back({tbl[i].dz, tbl[i].q, tbl[i].r});
            run_div(tbl[i].a, tbl[i].b, tbl[i].sgn, (tbl[i].b == '0) ? 1 : RUN_LAT,
                    0, $sformatf("tbl%0d", i));
        end

        // Randomized vectors against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic sg;
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom_range(1, 255);
                1:       b = '0;
                2:       b = a >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
`ifdef ALU_DIV_SIGNED_EN
            sg = $urandom_range(0, 1);
`else
            sg = 1'b0;
`endif
            exp_q.push_back(model_div(a, b, sg));
            run_div(a, b, sg, (b == '0) ? 1 : RUN_LAT, $urandom_range(0, 3),
                    $sformatf("rnd%0d", i));
        end

        // Back-pressure and an ignored mid-RUN request.
        dividend  = 32'd1000;
        divisor   = 32'd3;
`ifdef ALU_DIV_SIGNED_EN
        signed_in = 1'b0;
`endif
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("bp req_ready mid-run", {31'd0, req_ready}, 32'd0);
        dividend  = 32'd50;
        divisor   = 32'd5;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp res_valid", {31'd0, res_valid}, 32'd1);
        hq  = quotient;
        hr  = remainder;
        hdz = div_zero;
        check("bp quotient", hq, 32'd333);
        check("bp remainder", hr, 32'd1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp hold%0d quotient", c), quotient, hq);
            check($sformatf("bp hold%0d remainder", c), remainder, hr);
            check($sformatf("bp hold%0d flags", c), {29'd0, res_valid, req_ready, div_zero},
                  {29'd0, 1'b1, 1'b0, hdz});
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("bp req_ready after ack", {31'd0, req_ready}, 32'd1);
        check("bp res_valid after ack", {31'd0, res_valid}, 32'd0);
        // The pulsed request must not have been queued.
        repeat (40) begin
            @(posedge clk); #1;
        end
        check("bp no queued result", {31'd0, res_valid}, 32'd0);
        check("bp still idle", {31'd0, req_ready}, 32'd1);

        // Reset at RUN step 16.
        dividend  = 32'd12345;
        divisor   = 32'd67;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (16) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid-reset res_valid", {31'd0, res_valid}, 32'd0);
        check("mid-reset req_ready", {31'd0, req_ready}, 32'd1);
        check("mid-reset quotient", quotient, 32'd0);
        repeat (40) begin
            @(posedge clk); #1;
        end
        check("mid-reset no result", {31'd0, res_valid}, 32'd0);
        exp_q.push_back({1'b0, 32'd3, 32'd0});
        run_div(32'd9, 32'd3, 1'b0, RUN_LAT, 0, "post-reset 9/3");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global guard so a stuck handshake cannot hang the run.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, %0d vectors applied", n_vec);
        $fatal(1);
    end

endmodule
